regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential read-out engine for the MIPS-32 register file. The register file is the writer; this block is the reader.
- On a start command it walks a contiguous (optionally wrapping) range of register indices through one read port.
- Each sampled value is presented as an {index, data} beat on a valid/ready stream.
- Used for debug dump, context save and bench checking of architectural state.

Parameters:
- NUM_REGS, 32, number of registers in the file; must equal 2^ADDR_WIDTH.
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  cancel an active dump.
- first_index  input  ADDR_WIDTH  first register to read; latched on start.
- last_index  input  ADDR_WIDTH  last register to read, inclusive; latched on start.
- rf_addr  output  ADDR_WIDTH  read address to the register file read port.
- rf_data  input  DATA_WIDTH  combinational read data from the register file.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  ADDR_WIDTH  register index of the current beat.
- out_data  output  DATA_WIDTH  register value of the current beat.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the dump completes normally.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rf_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0; internal remaining count=0. Reset mid-dump drops any pending beat; no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 && abort=0 → RUN.
  - On that edge: rf_addr<=first_index; remaining<=((last_index-first_index) mod NUM_REGS)+1. Arithmetic is ADDR_WIDTH-bit wrapping; the count is ADDR_WIDTH+1 bits wide.
  - Range rules: last<first wraps through NUM_REGS-1 to 0; first==last gives 1 beat; first=0, last=NUM_REGS-1 gives NUM_REGS beats.
- RUN, on each edge where (!out_valid || out_ready):
  - Capture: out_data<=rf_data, out_index<=rf_addr, out_valid<=1.
  - If remaining==1 → DRAIN.
  - Else rf_addr<=rf_addr+1 (wraps NUM_REGS-1→0) and remaining<=remaining-1.
- RUN stall: when out_valid && !out_ready, rf_addr, remaining, out_index and out_data all hold.
- DRAIN: on out_ready (with out_valid=1) → out_valid<=0, done<=1 for exactly one cycle, state→IDLE.
- Throughput and latency:
  - One beat per cycle under continuous out_ready.
  - First out_valid is visible after the second posedge following start, i.e. one edge after entering RUN.
- Handshake rules:
  - A beat transfers on a posedge with out_valid && out_ready.
  - out_index and out_data stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on abort or reset.
- Coherence: rf_data is sampled at posedge. The register file writes on negedge, so a write at the preceding negedge is visible in the sample. Register 0 is read as stored; no zero forcing.
- abort=1 in RUN or DRAIN: next edge → IDLE, out_valid<=0, no done pulse, in-flight beat discarded. abort in IDLE has no effect; start+abort together in IDLE stays IDLE.
- start while busy is ignored. start in the same cycle as done (already in IDLE) is accepted.
- busy=1 in RUN and DRAIN; it is 0 in the cycle done is high.

Test Plan:
- Full dump: preload r[i]=0x1000+i; first=0, last=31, out_ready=1 → 32 consecutive beats, index 0..31, data 0x1000..0x101F; done pulses once after the last handshake; busy then 0.
- Backpressure: first=4, last=6, out_ready pattern 1,0,0,1,1 → beats {4,r4},{5,r5},{6,r6} only; out_data held through the stall cycles; no duplicates or drops.
- Wrap and single: first=30, last=1 → indices 30,31,0,1 in that order. first=last=5 → one beat {5,r5}, then done.
- Write coherence: dump 0..15 with out_ready=0 held at index 3; write r7=0xDEADBEEF; release out_ready → beat 7 carries 0xDEADBEEF.
- Abort/reset: abort after beat 10 of a 0..31 dump → out_valid=0 next cycle, no done, busy=0, and a new start is accepted. Drive reset low mid-RUN → all outputs 0 immediately (asynchronously).
- Illegal start: start pulsed during RUN with different indices → ignored; the original range completes unchanged.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for a register file: walks an inclusive,
// optionally wrapping range of register indices through a single read port
// and presents every sampled value as an {index, data} beat on a
// valid/ready stream.
module regfile_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_index,
  input  logic [ADDR_WIDTH-1:0] last_index,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  // Address increment relies on natural ADDR_WIDTH wrap-around, so the
  // register count must be an exact power of two.
  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_bad_num_regs
    $error("NUM_REGS must equal 2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_index_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] span_d;
  logic [ADDR_WIDTH:0]   remaining_init_d;
  logic [ADDR_WIDTH-1:0] rf_addr_inc_d;
  logic                  advance_d;

  // Range length, next read address and the "output slot is free" condition.
  always_comb begin
    span_d           = last_index - first_index;
    remaining_init_d = {1'b0, span_d} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    rf_addr_inc_d    = rf_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    advance_d        = !out_valid_q || out_ready;
  end

  // Dump sequencer: state, read pointer, output beat register and done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rf_addr_q   <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // start together with abort is treated as a cancelled request.
          if (start && !abort) begin
            state_q     <= RUN;
            rf_addr_q   <= first_index;
            remaining_q <= remaining_init_d;
          end
        end

        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else if (advance_d) begin
            // Capture a new beat whenever the previous one has left (or
            // leaves on this very edge), giving one beat per cycle.
            out_data_q  <= rf_data;
            out_index_q <= rf_addr_q;
            out_valid_q <= 1'b1;
            if (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
              state_q <= DRAIN;
            end else begin
              rf_addr_q   <= rf_addr_inc_d;
              remaining_q <= remaining_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
          end
        end

        DRAIN: begin
          // Last beat is parked in the output register; finish when it goes.
          if (abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register file drives rf_data,
// and every dump is checked against an expected list of {index, data} beats
// built from the range rules, plus handshake stability, done/busy timing,
// abort and asynchronous reset behaviour.
module tb_regfile_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_index;
  logic [AW-1:0] last_index;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf_mem [N];

  int vectors     = 0;
  int miscompares = 0;

  int          exp_idx[$];
  logic [31:0] exp_dat[$];

  always #5 clock = ~clock;

  // Register file read port is combinational; writes happen on negedge.
  assign rf_data = rf_mem[rf_addr];

  regfile_dump_reader #(
    .NUM_REGS  (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_index(first_index),
    .last_index (last_index),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1,1,
  //       3 hold at index 3 and write r7 during the stall.
  // abort_after: abort once that many beats have transferred (-1: never).
  // inject: pulse start with a different range while the dump is running.
  task automatic run_dump(input int first, input int last, input int mode,
                          input int abort_after, input bit inject);
    int            n;
    int            beats = 0;
    int            cyc = 0;
    int            hold = 0;
    bit            last_beat = 1'b0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [AW-1:0] pidx = '0;
    logic [DW-1:0] pdat = '0;
    int            pat[5] = '{1, 0, 0, 1, 1};

    exp_idx.delete();
    exp_dat.delete();
    n = (((last - first) % N) + N) % N + 1;
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back((first + k) % N);
      exp_dat.push_back(rf_mem[(first + k) % N]);
    end
    $display("dump first=%0d last=%0d beats=%0d mode=%0d abort_after=%0d inject=%0d",
             first, last, n, mode, abort_after, inject);

    first_index = first[AW-1:0];
    last_index  = last[AW-1:0];
    start       = 1'b1;
    abort       = 1'b0;
    out_ready   = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_not_yet", out_valid, 0);
    chk("done_low_after_start", done, 0);

    while (cyc < 600) begin
      if (cyc == 1) begin
        chk("first_valid_latency", out_valid, 1);
        chk("first_index", out_index, first[AW-1:0]);
      end
      if (pv && !pr) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_index_held", out_index, pidx);
        chk("stall_data_held", out_data, pdat);
      end
      if (inject && cyc == 2) begin
        start       = 1'b1;
        first_index = first_index + 5'd7;
        last_index  = first_index + 5'd2;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = pat[cyc % 5][0];
        default: begin
          if (out_valid && out_index == 5'd3 && hold < 4) begin
            out_ready = 1'b0;
            hold++;
            if (hold == 2) begin
              rf_mem[7] = 32'hDEADBEEF;
              foreach (exp_idx[j]) if (exp_idx[j] == 7) exp_dat[j] = 32'hDEADBEEF;
            end
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && out_ready) begin
        if (exp_idx.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          $display("beat %0d: index=%0d data=%08h expected index=%0d data=%08h",
                   beats, out_index, out_data, exp_idx[0], exp_dat[0]);
          chk("beat_index", out_index, 64'(exp_idx[0]));
          chk("beat_data", out_data, exp_dat[0]);
          void'(exp_idx.pop_front());
          void'(exp_dat.pop_front());
          beats++;
          if (exp_idx.size() == 0) last_beat = 1'b1;
        end
      end
      pv   = out_valid;
      pr   = out_ready;
      pidx = out_index;
      pdat = out_data;
      @(negedge clock);
      cyc++;
      if (last_beat) begin
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("valid_low_at_done", out_valid, 0);
        out_ready = 1'b0;
        return;
      end
      chk("no_early_done", done, 0);
      chk("busy_during_dump", busy, 1);
      if (abort_after >= 0 && beats == abort_after) begin
        abort     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", busy, 0);
        chk("abort_no_done", done, 0);
        @(negedge clock);
        chk("abort_no_done_later", done, 0);
        return;
      end
    end
    chk("dump_timeout", 0, 1);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    out_ready   = 1'b0;
    first_index = '0;
    last_index  = '0;
    for (int i = 0; i < N; i++) rf_mem[i] = 32'h1000 + i;

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clock);

    // Directed dumps; each begins in the done cycle of the previous one.
    run_dump(0, 31, 0, -1, 1'b0);
    run_dump(4, 6, 2, -1, 1'b0);
    run_dump(30, 1, 1, -1, 1'b0);
    run_dump(5, 5, 0, -1, 1'b0);
    run_dump(0, 15, 3, -1, 1'b0);
    run_dump(0, 31, 0, 10, 1'b0);
    run_dump(2, 9, 1, -1, 1'b0);
    run_dump(8, 20, 0, -1, 1'b1);
    @(negedge clock);
    chk("idle_after_dumps", busy, 0);

    // start together with abort in IDLE stays IDLE; abort alone does nothing.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_valid", out_valid, 0);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);

    // Randomised contents and ranges.
    for (int i = 0; i < N; i++) rf_mem[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, -1, 1'b0);
    end

    // Asynchronous reset in the middle of a dump.
    @(negedge clock);
    first_index = 5'd0;
    last_index  = 5'd31;
    start       = 1'b1;
    out_ready   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_reset_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rf_addr", rf_addr, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_index", out_index, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clock);
    reset     = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_done", done, 0);
    run_dump(28, 3, 1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
